// File: rtl/lim_brick_pkg.sv
// Shared types and constants for the LiM SRAM brick wordline path (driver + encoder).
`ifndef BITS_ADDR_LIM_BRICK
`define BITS_ADDR_LIM_BRICK 5
`endif

package lim_brick_pkg;

    localparam int LIM_BRICK_ADDR_W  = `BITS_ADDR_LIM_BRICK;
    localparam int LIM_BRICK_WL_W    = 1 << LIM_BRICK_ADDR_W;
    localparam int LIM_BRICK_CNT_W   = 4;
    localparam int LIM_BRICK_CNT_MAX = (1 << LIM_BRICK_CNT_W) - 1;

    typedef logic [LIM_BRICK_CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ACT  = 2'd2,
        DONE = 2'd3
    } wl_drv_state_t;

    // Phase counters count down to zero, so an N-cycle phase loads N-1.
    function automatic cnt_t cyc_to_cnt(input int cyc);
        return cnt_t'(cyc - 1);
    endfunction

endpackage

// File: rtl/wl_driver_brick_if.sv
// Request channel from the brick access controller: row address + op over valid/ready.
interface wl_driver_brick_if
    import lim_brick_pkg::*;
#(
    parameter int ADDR_WIDTH = LIM_BRICK_ADDR_W
);

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;

    modport master (
        output req_valid,
        output req_addr,
        output req_we,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_we,
        output req_ready
    );

endinterface

// File: rtl/decoder_brick.sv
// Combinational row address -> one-hot wordline decoder, inverse of the brick encoder.
// Zero latency; no flow control, output is all-zero while i_en is low.
module decoder_brick
    import lim_brick_pkg::*;
#(
    parameter int ADDR_WIDTH = LIM_BRICK_ADDR_W,
    parameter int WL_WIDTH   = 1 << ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_en,
    output logic [WL_WIDTH-1:0]   o_wl
);

    always_comb begin
        o_wl = '0;
        if (i_en) begin
            o_wl[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/wl_driver_brick.sv
// Wordline driver: sequences precharge, one-hot wordline drive and a done pulse per access.
// Latency: PRE_CYC + ACT_CYC + 1 cycles from accept to done; all outputs registered.
// Backpressure: req_ready only in IDLE, so one access per PRE_CYC + ACT_CYC + 2 cycles.
module wl_driver_brick
    import lim_brick_pkg::*;
#(
    parameter int ADDR_WIDTH = LIM_BRICK_ADDR_W,
    parameter int WL_WIDTH   = 1 << ADDR_WIDTH,
    parameter int PRE_CYC    = 1,
    parameter int ACT_CYC    = 2
) (
    input  logic                clk,
    input  logic                rst_b,
    wl_driver_brick_if.slave    req,
    output logic [WL_WIDTH-1:0] wl,
    output logic                wl_we,
    output logic                pre_b,
    output logic                done,
    output logic                busy
);

    if (PRE_CYC < 1 || PRE_CYC > LIM_BRICK_CNT_MAX) begin : g_bad_pre_cyc
        $error("wl_driver_brick: PRE_CYC must be within 1..15");
    end
    if (ACT_CYC < 1 || ACT_CYC > LIM_BRICK_CNT_MAX) begin : g_bad_act_cyc
        $error("wl_driver_brick: ACT_CYC must be within 1..15");
    end
    if (WL_WIDTH != (1 << ADDR_WIDTH)) begin : g_bad_wl_width
        $error("wl_driver_brick: WL_WIDTH must equal 1 << ADDR_WIDTH");
    end

    localparam cnt_t PRE_LOAD = cyc_to_cnt(PRE_CYC);
    localparam cnt_t ACT_LOAD = cyc_to_cnt(ACT_CYC);

    wl_drv_state_t         r_state;
    wl_drv_state_t         w_state_nxt;
    cnt_t                  r_cnt;
    cnt_t                  w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [WL_WIDTH-1:0]   r_wl;
    logic [WL_WIDTH-1:0]   w_dec;
    logic                  r_wl_we;
    logic                  r_pre_b;
    logic                  r_done;
    logic                  r_busy;
    logic                  w_pre_b_nxt;
    logic                  w_done_nxt;
    logic                  w_dec_en;
    logic                  w_accept;

    assign req.req_ready = (r_state == IDLE);
    assign w_accept      = req.req_valid && req.req_ready;

    decoder_brick #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WL_WIDTH   (WL_WIDTH)
    ) u_decoder (
        .i_addr (r_addr),
        .i_en   (w_dec_en),
        .o_wl   (w_dec)
    );

    // w_dec_en marks the cycles whose following cycle must drive the row.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pre_b_nxt = 1'b1;
        w_done_nxt  = 1'b0;
        w_dec_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = PRE;
                    w_cnt_nxt   = PRE_LOAD;
                    w_pre_b_nxt = 1'b0;
                end
            end
            PRE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ACT;
                    w_cnt_nxt   = ACT_LOAD;
                    w_dec_en    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - cnt_t'(1);
                    w_pre_b_nxt = 1'b0;
                end
            end
            ACT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - cnt_t'(1);
                    w_dec_en  = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wl    <= '0;
            r_wl_we <= 1'b0;
            r_pre_b <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wl    <= w_dec;
            r_wl_we <= w_dec_en && r_we;
            r_pre_b <= w_pre_b_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_addr <= '0;
            r_we   <= 1'b0;
        end else if (w_accept) begin
            r_addr <= req.req_addr;
            r_we   <= req.req_we;
        end
    end

    assign wl    = r_wl;
    assign wl_we = r_wl_we;
    assign pre_b = r_pre_b;
    assign done  = r_done;
    assign busy  = r_busy;

endmodule

// File: tb/tb_wl_driver_brick.sv
// Bench for wl_driver_brick: default instance (1/2 cycles) plus a 3/4-cycle instance, scoreboarded.
module tb_wl_driver_brick;
    import lim_brick_pkg::*;

    localparam int AW   = LIM_BRICK_ADDR_W;
    localparam int WW   = LIM_BRICK_WL_W;
    localparam int PRE0 = 1;
    localparam int ACT0 = 2;
    localparam int PRE1 = 3;
    localparam int ACT1 = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    wl_driver_brick_if #(.ADDR_WIDTH(AW)) rq0 ();
    wl_driver_brick_if #(.ADDR_WIDTH(AW)) rq1 ();

    logic [WW-1:0] wl_o    [2];
    logic          wl_we_o [2];
    logic          pre_b_o [2];
    logic          done_o  [2];
    logic          busy_o  [2];
    logic          ready_o [2];

    assign ready_o[0] = rq0.req_ready;
    assign ready_o[1] = rq1.req_ready;

    wl_driver_brick #(.ADDR_WIDTH(AW), .WL_WIDTH(WW), .PRE_CYC(PRE0), .ACT_CYC(ACT0)) u_dut0 (
        .clk   (clk),
        .rst_b (rst_b),
        .req   (rq0.slave),
        .wl    (wl_o[0]),
        .wl_we (wl_we_o[0]),
        .pre_b (pre_b_o[0]),
        .done  (done_o[0]),
        .busy  (busy_o[0])
    );

    wl_driver_brick #(.ADDR_WIDTH(AW), .WL_WIDTH(WW), .PRE_CYC(PRE1), .ACT_CYC(ACT1)) u_dut1 (
        .clk   (clk),
        .rst_b (rst_b),
        .req   (rq1.slave),
        .wl    (wl_o[1]),
        .wl_we (wl_we_o[1]),
        .pre_b (pre_b_o[1]),
        .done  (done_o[1]),
        .busy  (busy_o[1])
    );

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int            pre_n      [2];
    int            act_n      [2];
    int            done_n     [2];
    int            done_total [2];
    logic [WW-1:0] cap_wl     [2];
    logic          cap_we     [2];
    bit            cap_ok     [2];

    // Reference brick encoder: one-hot wordline back to a row index.
    function automatic int enc(input logic [WW-1:0] v);
        int r = -1;
        for (int i = 0; i < WW; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Per-cycle invariants plus scoreboard: each completed access is compared against the oldest request.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t          e;
            bit            has;
            int            pe;
            int            ae;
            logic [WW-1:0] ewl;
            checks++;
            if ($countones(wl_o[d]) > 1) begin
                errors++;
                $display("FAIL inv_onehot dut%0d wl=%h required popcount<=1", d, wl_o[d]);
            end
            checks++;
            if (wl_o[d] != '0 && pre_b_o[d] !== 1'b1) begin
                errors++;
                $display("FAIL inv_overlap dut%0d wl=%h pre_b=%b required no overlap", d, wl_o[d], pre_b_o[d]);
            end
            checks++;
            if (wl_we_o[d] === 1'b1 && wl_o[d] == '0) begin
                errors++;
                $display("FAIL inv_we_idle dut%0d wl_we=1 wl=0 required wl_we=0", d);
            end
            checks++;
            if (ready_o[d] !== !busy_o[d]) begin
                errors++;
                $display("FAIL inv_ready dut%0d req_ready=%b busy=%b required req_ready=!busy", d, ready_o[d], busy_o[d]);
            end
            if (!rst_b) begin
                pre_n[d]  = 0;
                act_n[d]  = 0;
                done_n[d] = 0;
            end else begin
                if (!pre_b_o[d]) pre_n[d]++;
                if (wl_o[d] != '0) begin
                    if (act_n[d] == 0) begin
                        cap_wl[d] = wl_o[d];
                        cap_we[d] = wl_we_o[d];
                        cap_ok[d] = 1'b1;
                    end else if (wl_o[d] !== cap_wl[d] || wl_we_o[d] !== cap_we[d]) begin
                        cap_ok[d] = 1'b0;
                    end
                    act_n[d]++;
                end
                if (done_o[d]) begin
                    done_n[d]++;
                    done_total[d]++;
                end else if (done_n[d] > 0) begin
                    pe  = (d == 0) ? PRE0 : PRE1;
                    ae  = (d == 0) ? ACT0 : ACT1;
                    has = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
                    checks++;
                    if (!has) begin
                        errors++;
                        $display("FAIL sb_unexpected dut%0d wl=%h required no access", d, cap_wl[d]);
                    end else begin
                        e   = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        ewl = '0;
                        ewl[e.addr] = 1'b1;
                        if (cap_wl[d] !== ewl || enc(cap_wl[d]) != int'(e.addr) || cap_we[d] !== e.we) begin
                            errors++;
                            $display("FAIL sb_data dut%0d wl=%h we=%b required wl=%h we=%b", d, cap_wl[d], cap_we[d], ewl, e.we);
                        end
                        checks++;
                        if (pre_n[d] != pe || act_n[d] != ae || done_n[d] != 1 || !cap_ok[d]) begin
                            errors++;
                            $display("FAIL sb_timing dut%0d pre=%0d act=%0d done=%0d stable=%0d required %0d/%0d/1/1",
                                     d, pre_n[d], act_n[d], done_n[d], cap_ok[d], pe, ae);
                        end
                    end
                    pre_n[d]  = 0;
                    act_n[d]  = 0;
                    done_n[d] = 0;
                end
            end
        end
    end

    task automatic drive(input int d, input logic v, input logic [AW-1:0] a, input logic we);
        if (d == 0) begin
            rq0.req_valid = v;
            rq0.req_addr  = a;
            rq0.req_we    = we;
        end else begin
            rq1.req_valid = v;
            rq1.req_addr  = a;
            rq1.req_we    = we;
        end
    endtask

    // Presents one request, returns 1 time unit after the accepting edge.
    task automatic send(input int d, input logic [AW-1:0] a, input logic we);
        bit ok = 1'b0;
        @(negedge clk);
        drive(d, 1'b1, a, we);
        for (int i = 0; i < 40; i++) begin
            if (ready_o[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout dut%0d req_ready=%b required 1 within 40 cycles", d, ready_o[d]);
        end else if (d == 0) begin
            exp_q0.push_back('{addr: a, we: we});
        end else begin
            exp_q1.push_back('{addr: a, we: we});
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, a, we);
    endtask

    task automatic wait_idle(input int d);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy_o[d]) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout dut%0d busy=%b required 0", d, busy_o[d]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wl_o[d] !== '0) begin errors++; $display("FAIL rst_wl dut%0d got=%h required 0", d, wl_o[d]); end
            checks++;
            if (wl_we_o[d] !== 1'b0) begin errors++; $display("FAIL rst_wl_we dut%0d got=%b required 0", d, wl_we_o[d]); end
            checks++;
            if (pre_b_o[d] !== 1'b1) begin errors++; $display("FAIL rst_pre_b dut%0d got=%b required 1", d, pre_b_o[d]); end
            checks++;
            if (done_o[d] !== 1'b0) begin errors++; $display("FAIL rst_done dut%0d got=%b required 0", d, done_o[d]); end
            checks++;
            if (busy_o[d] !== 1'b0) begin errors++; $display("FAIL rst_busy dut%0d got=%b required 0", d, busy_o[d]); end
            checks++;
            if (ready_o[d] !== 1'b1) begin errors++; $display("FAIL rst_ready dut%0d got=%b required 1", d, ready_o[d]); end
        end
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Cycle-exact waveform after accept, derived from the phase lengths of instance d.
    task automatic check_waveform(input int d, input int p, input int a, input logic [AW-1:0] addr, input logic we, input string nm);
        logic [WW-1:0] ewl;
        logic [3:0]    ectl;
        logic [3:0]    gctl;
        for (int k = 1; k <= p + a + 2; k++) begin
            @(negedge clk);
            ewl = '0;
            if (k > p && k <= p + a) ewl[addr] = 1'b1;
            ectl = {(k > p), (k > p && k <= p + a && we), (k == p + a + 1), (k == p + a + 2)};
            gctl = {pre_b_o[d], wl_we_o[d], done_o[d], ready_o[d]};
            checks++;
            if (wl_o[d] !== ewl || gctl !== ectl) begin
                errors++;
                $display("FAIL %s cycle%0d wl=%h pre_b/we/done/rdy=%b required wl=%h %b", nm, k, wl_o[d], gctl, ewl, ectl);
            end
        end
    endtask

    task automatic test_single_read();
        send(0, AW'(5), 1'b0);
        check_waveform(0, PRE0, ACT0, AW'(5), 1'b0, "read_a5");
        wait_idle(0);
        checks++;
        if (exp_q0.size() != 0) begin errors++; $display("FAIL read_a5_sb left=%0d required 0", exp_q0.size()); end
    endtask

    task automatic test_write_long();
        send(1, AW'(31), 1'b1);
        check_waveform(1, PRE1, ACT1, AW'(31), 1'b1, "write_a31");
        wait_idle(1);
        checks++;
        if (exp_q1.size() != 0) begin errors++; $display("FAIL write_a31_sb left=%0d required 0", exp_q1.size()); end
    endtask

    task automatic test_back_to_back();
        int base = done_total[0];
        bit ok;
        @(negedge clk);
        drive(0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (ready_o[0]) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b_timeout req%0d req_ready=%b required 1", i, ready_o[0]); end
            drive(0, 1'b1, AW'(i), 1'b0);
            exp_q0.push_back('{addr: AW'(i), we: 1'b0});
            @(negedge clk);
            checks++;
            if (ready_o[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready req%0d got=%b required 0", i, ready_o[0]); end
        end
        drive(0, 1'b0, '0, 1'b0);
        wait_idle(0);
        repeat (8) @(negedge clk);
        checks++;
        if (done_total[0] - base != 3) begin errors++; $display("FAIL b2b_dones got=%0d required 3", done_total[0] - base); end
        checks++;
        if (exp_q0.size() != 0) begin errors++; $display("FAIL b2b_sb left=%0d required 0", exp_q0.size()); end
    endtask

    task automatic test_addr_change();
        send(0, AW'(7), 1'b0);
        @(negedge clk);
        drive(0, 1'b0, AW'(9), 1'b1);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (wl_o[0] !== 32'h0000_0080 || wl_we_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL addr_hold cycle%0d wl=%h we=%b required wl=00000080 we=0", k, wl_o[0], wl_we_o[0]);
            end
        end
        wait_idle(0);
        checks++;
        if (exp_q0.size() != 0) begin errors++; $display("FAIL addr_hold_sb left=%0d required 0", exp_q0.size()); end
    endtask

    task automatic test_reset_abort();
        int base = done_total[0];
        send(0, AW'(12), 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (wl_o[0] !== 32'h0000_1000 || wl_we_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_act wl=%h we=%b required wl=00001000 we=1", wl_o[0], wl_we_o[0]);
        end
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (wl_o[0] !== '0 || wl_we_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_async wl=%h we=%b required wl=0 we=0", wl_o[0], wl_we_o[0]);
        end
        exp_q0.delete();
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ready_o[0] !== 1'b1 || pre_b_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_release rdy=%b pre_b=%b busy=%b required 1 1 0", ready_o[0], pre_b_o[0], busy_o[0]);
        end
        checks++;
        if (done_total[0] != base) begin errors++; $display("FAIL abort_done pulses=%0d required 0", done_total[0] - base); end
    endtask

    task automatic test_sweep();
        int base = done_total[0];
        for (int a = 0; a < WW; a++) begin
            send(0, AW'(a), a[0]);
        end
        wait_idle(0);
        checks++;
        if (done_total[0] - base != WW) begin errors++; $display("FAIL sweep_dones got=%0d required %0d", done_total[0] - base, WW); end
        checks++;
        if (exp_q0.size() != 0) begin errors++; $display("FAIL sweep_sb left=%0d required 0", exp_q0.size()); end
    endtask

    initial begin
        rst_b = 1'b1;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        #1;
        rst_b = 1'b0;
        test_reset();
        test_single_read();
        test_write_long();
        test_back_to_back();
        test_addr_change();
        test_reset_abort();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
